// File: rtl/frame_buffer_arbiter.sv
// Frame RAM arbiter: display fetch reads always win the single RAM port; the
// game-logic writer is served through a three-state handshake only in slots
// the display does not need. Also delivers the fetched pixel stream at a fixed
// latency and marks the first active pixel of each frame.
module frame_buffer_arbiter #(
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned FRAME_H = 480,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        frame_x,
  input  logic [9:0]        frame_y,
  input  logic              frame_there,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_start
);

  localparam int unsigned NumPix = FRAME_W * FRAME_H;
  // Flag stages ahead of the output register; with it the total is RAM_LAT+2.
  localparam int unsigned DlyLen = RAM_LAT + 1;

  typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic              issue_wr;
  logic              wr_in_range;
  logic              start_in;
  logic [ADDR_W-1:0] x_ext, y_ext, rd_addr;
  logic [DlyLen-1:0] there_dly_q, start_dly_q;

  assign x_ext       = ADDR_W'(frame_x);
  assign y_ext       = ADDR_W'(frame_y);
  assign wr_in_range = 32'(wr_addr) < NumPix;
  assign start_in    = frame_there && (frame_x == '0) && (frame_y == '0);

  // Linear read address y*FRAME_W + x; 640 = 512 + 128 avoids a multiplier.
  if (FRAME_W == 640) begin : g_mul640
    assign rd_addr = (y_ext << 9) + (y_ext << 7) + x_ext;
  end else begin : g_mul
    assign rd_addr = y_ext * ADDR_W'(FRAME_W) + x_ext;
  end

  // Writer FSM next state; a request is only accepted in a slot the display leaves free.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    issue_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_req && !frame_there) begin
          issue_wr = 1'b1;
          err_d    = !wr_in_range;
          state_d  = StWrite;
        end
      end
      StWrite: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    wr_ack = (state_q == StAck);
    wr_err = (state_q == StAck) && err_q;
  end

  // Writer FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // RAM port slot: display read, else writer, else idle with the address held.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (frame_there) begin
      ram_addr <= rd_addr;
      ram_we   <= 1'b0;
    end else if (issue_wr) begin
      ram_addr  <= wr_addr;
      ram_wdata <= wr_data;
      ram_we    <= wr_in_range;
    end else begin
      ram_we <= 1'b0;
    end
  end

  // Delay the in-frame and first-pixel flags to line up with RAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      there_dly_q <= '0;
      start_dly_q <= '0;
    end else begin
      there_dly_q <= {there_dly_q[DlyLen-2:0], frame_there};
      start_dly_q <= {start_dly_q[DlyLen-2:0], start_in};
    end
  end

  // Output pixel register; blanking outputs black.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= there_dly_q[DlyLen-1];
      pix_data    <= there_dly_q[DlyLen-1] ? ram_rdata : '0;
      frame_start <= start_dly_q[DlyLen-1];
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: a pixel scoreboard checks the fetched stream
// every cycle while directed sequences exercise the writer handshake and reset.
module tb_frame_buffer_arbiter;

  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 1;

  logic          clk;
  logic          reset;
  logic [9:0]    frame_x, frame_y;
  logic          frame_there;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, wr_err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          frame_start;

  frame_buffer_arbiter #(
    .FRAME_W(640), .FRAME_H(480), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .frame_x(frame_x), .frame_y(frame_y), .frame_there(frame_there),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start)
  );

  typedef struct {
    int         due;
    logic [9:0] val;  // {pix_valid, frame_start, pix_data}
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            fs_count = 0;
  logic          there_q = 1'b0;
  logic          nxt_rst = 1'b1;
  logic          nxt_req = 1'b0;
  logic [AW-1:0] nxt_addr = '0;
  logic [DW-1:0] nxt_data = '0;

  // RAM content is a fixed function of the address so reads are predictable.
  function automatic logic [7:0] pix_fn(input logic [18:0] a);
    return (a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]}) + 8'h5a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    there_q = frame_there;
  end

  // Single-cycle-latency RAM read model.
  initial begin
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      ram_rdata <= pix_fn(ram_addr);
    end
  end

  // Output monitor: pixel scoreboard, read-slot write guard, frame_start count.
  initial forever begin
    @(negedge clk);
    if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq("pix", 32'({pix_valid, frame_start, pix_data}), 32'(e.val));
    end
    if (there_q) check_eq("we_in_read_slot", 32'(ram_we), 32'd0);
    if (frame_start) fs_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs on the falling edge and log the expected pixel.
  task automatic step(input bit there, input int x, input int y);
    exp_t e;
    @(negedge clk);
    reset       = nxt_rst;
    frame_there = there;
    frame_x     = 10'(x);
    frame_y     = 10'(y);
    wr_req      = nxt_req;
    wr_addr     = nxt_addr;
    wr_data     = nxt_data;
    if (nxt_rst) sb_q.delete();
    e.due = cyc + LAT + 2;
    if (nxt_rst || !there) e.val = '0;
    else e.val = {1'b1, (x == 0 && y == 0), pix_fn(19'(y * 640 + x))};
    sb_q.push_back(e);
  endtask

  task automatic pix(input int x, input int y);
    step(1'b1, x, y);
  endtask

  task automatic idle();
    step(1'b0, 0, 0);
  endtask

  // Observe just after the next rising edge.
  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out"},
             32'({ram_we, wr_ack, wr_err, pix_valid, frame_start, pix_data, ram_wdata}), 32'd0);
    check_eq({tag, "_addr"}, 32'(ram_addr), 32'd0);
  endtask

  initial begin
    int rows[4] = '{0, 1, 2, 479};
    int acks;
    reset = 1'b1; frame_there = 1'b0; frame_x = '0; frame_y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;

    // Power-on reset.
    idle(); idle(); sample();
    check_all_zero("reset_state");
    nxt_rst = 1'b0;

    // Display read address and latency.
    pix(5, 2); sample();
    check_eq("rd_addr_1285", 32'(ram_addr), 32'd1285);
    check_eq("rd_we", 32'(ram_we), 32'd0);
    idle(); sample();
    check_eq("addr_hold", 32'(ram_addr), 32'd1285);
    pix(639, 479); sample();
    check_eq("rd_addr_last", 32'(ram_addr), 32'd307199);
    idle(); idle(); idle();

    // Simple write.
    nxt_req = 1'b1; nxt_addr = 19'd100; nxt_data = 8'haa;
    idle(); sample();
    check_eq("wr_issue", 32'({ram_we, wr_ack}), 32'b10);
    check_eq("wr_addr", 32'(ram_addr), 32'd100);
    check_eq("wr_data", 32'(ram_wdata), 32'haa);
    idle(); sample();
    check_eq("wr_ack", 32'({ram_we, wr_ack, wr_err}), 32'b010);
    nxt_req = 1'b0;
    idle(); sample();
    check_eq("wr_done", 32'({ram_we, wr_ack}), 32'b00);

    // Back-to-back with request held: writes three cycles apart.
    nxt_req = 1'b1; nxt_addr = 19'd300; nxt_data = 8'h3c;
    for (int i = 0; i < 6; i++) begin
      idle(); sample();
      check_eq("b2b_we", 32'(ram_we), 32'((i % 3) == 0));
      check_eq("b2b_ack", 32'(wr_ack), 32'((i % 3) == 1));
    end
    nxt_req = 1'b0;
    idle(); idle(); idle();

    // Writer stalled behind 50 display cycles.
    nxt_req = 1'b1; nxt_addr = 19'd200; nxt_data = 8'h33;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      pix(10 + i, 7); sample();
      check_eq("stall_we", 32'(ram_we), 32'd0);
      acks += int'(wr_ack);
    end
    check_eq("stall_no_ack", 32'(acks), 32'd0);
    idle(); sample();
    check_eq("stall_issue", 32'({ram_we, ram_addr, ram_wdata}), {1'b1, 19'd200, 8'h33});
    pix(0, 8); sample();
    check_eq("stall_ack", 32'({ram_we, wr_ack, wr_err}), 32'b010);
    check_eq("stall_read_addr", 32'(ram_addr), 32'd5120);
    nxt_req = 1'b0;
    idle(); idle(); idle();

    // Last legal address is written; first illegal one is rejected.
    nxt_req = 1'b1; nxt_addr = 19'd307199; nxt_data = 8'h77;
    idle(); sample();
    check_eq("edge_in_range", 32'({ram_we, ram_addr}), {1'b1, 19'd307199});
    idle(); sample();
    check_eq("edge_in_ack", 32'({wr_ack, wr_err}), 32'b10);
    nxt_req = 1'b0;
    idle(); idle();
    nxt_req = 1'b1; nxt_addr = 19'd307200; nxt_data = 8'h55;
    idle(); sample();
    check_eq("oor_no_we", 32'({ram_we, wr_ack}), 32'b00);
    idle(); sample();
    check_eq("oor_ack_err", 32'({ram_we, wr_ack, wr_err}), 32'b011);
    nxt_req = 1'b0;
    idle(); sample();
    check_eq("oor_done", 32'({wr_ack, wr_err}), 32'b00);

    // Reset mid-stream with a write in flight: no ack afterwards.
    pix(1, 1); pix(2, 1);
    nxt_req = 1'b1; nxt_addr = 19'd400; nxt_data = 8'h11;
    idle(); sample();
    check_eq("pre_rst_issue", 32'(ram_we), 32'd1);
    nxt_rst = 1'b1;
    pix(3, 3); sample();
    check_all_zero("mid_reset");
    pix(4, 3);
    nxt_rst = 1'b0; nxt_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      idle(); sample();
      acks += int'(wr_ack);
    end
    check_eq("rst_no_ack", 32'(acks), 32'd0);

    // Two frames of scan: rows 0..2 and the last row, with blanking between.
    fs_count = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 4; r++) begin
        for (int x = 0; x < 640; x++) pix(x, rows[r]);
        for (int b = 0; b < 16; b++) idle();
      end
    end
    for (int b = 0; b < 8; b++) idle();
    sample();
    check_eq("frame_start_count", 32'(fs_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
